// File: rtl/mult_rr_scheduler_pkg.sv
// Shared defaults and tag-entry layout for the
// multiplier round-robin scheduler.
package mult_rr_scheduler_pkg;

  localparam int BIT_WIDTH_DEF   = 8;
  localparam int NUM_REQ_DEF     = 4;
  localparam int MUL_LATENCY_DEF = 1;

  // Wide enough for the largest supported NUM_REQ (16).
  localparam int TAG_ID_W = 4;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward
// from the last accepted lane; pointer moves on accept.
module mult_rr_scheduler_rr_arbiter
  import mult_rr_scheduler_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               hold_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               gnt_vld_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] id;
  logic            found;
  int              idx;

  always_comb begin
    gnt_o = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      sel = ID_W'(idx);
      if (!found && valid_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        id         = sel;
      end
    end
    if (hold_i || rst_i) begin
      gnt_o = '0;
      found = 1'b0;
    end
  end

  // A grant is only issued to a valid lane, so it is
  // always an accepted transfer.
  assign gnt_vld_o = found;
  assign gnt_id_o  = id;
  assign ptr_d     = found ? id : ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one pipelined multiplier among NUM_REQ lanes,
// tagging each issue so products return to their lane.
module mult_rr_scheduler
  import mult_rr_scheduler_pkg::*;
#(
  parameter  int BIT_WIDTH   = BIT_WIDTH_DEF,
  parameter  int NUM_REQ     = NUM_REQ_DEF,
  parameter  int MUL_LATENCY = MUL_LATENCY_DEF,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] i_req_weight,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] i_req_feature,
  input  logic                         i_hold,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic [BIT_WIDTH-1:0]         o_mul_a,
  output logic [BIT_WIDTH-1:0]         o_mul_b,
  output logic                         o_mul_en,
  input  logic [2*BIT_WIDTH-1:0]       i_mul_p,
  output logic [NUM_REQ-1:0]           o_rsp_valid,
  output logic [2*BIT_WIDTH-1:0]       o_rsp_data,
  output logic                         o_busy
);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;

  mult_rr_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .valid_i   (i_req_valid),
    .hold_i    (i_hold),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .gnt_vld_o (gnt_vld)
  );

  assign o_req_ready = gnt;

  logic [BIT_WIDTH-1:0]   a_q, a_d;
  logic [BIT_WIDTH-1:0]   b_q, b_d;
  logic                   en_q, en_d;
  logic [ID_W-1:0]        id_q, id_d;
  tag_t                   tag_q [MUL_LATENCY];
  tag_t                   tag_in;
  tag_t                   tail;
  logic [NUM_REQ-1:0]     rsp_q, rsp_d;
  logic [2*BIT_WIDTH-1:0] data_q, data_d;
  logic                   tag_any;

  always_comb begin
    en_d = gnt_vld;
    a_d  = a_q;
    b_d  = b_q;
    id_d = id_q;
    if (gnt_vld) begin
      a_d  = i_req_weight[int'(gnt_id)*BIT_WIDTH +: BIT_WIDTH];
      b_d  = i_req_feature[int'(gnt_id)*BIT_WIDTH +: BIT_WIDTH];
      id_d = gnt_id;
    end
  end

  // The issue register is the head of the tag pipe; the
  // MUL_LATENCY stages after it line the tail up with i_mul_p.
  always_comb begin
    tag_in                = '0;
    tag_in.vld            = en_q;
    tag_in.id[ID_W-1:0]   = id_q;
    tail                  = tag_q[MUL_LATENCY-1];
    tag_any               = 1'b0;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      tag_any = tag_any | tag_q[i].vld;
    end
    rsp_d  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_d[k] = tail.vld && (tail.id == TAG_ID_W'(k));
    end
    data_d = tail.vld ? i_mul_p : data_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q    <= '0;
      b_q    <= '0;
      en_q   <= 1'b0;
      id_q   <= '0;
      rsp_q  <= '0;
      data_q <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      en_q     <= en_d;
      id_q     <= id_d;
      rsp_q    <= rsp_d;
      data_q   <= data_d;
      tag_q[0] <= tag_in;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign o_mul_a     = a_q;
  assign o_mul_b     = b_q;
  assign o_mul_en    = en_q;
  assign o_rsp_valid = rsp_q;
  assign o_rsp_data  = data_q;
  assign o_busy      = en_q | tag_any | (|rsp_q);

endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
Shares one pipelined pixel multiplier (weight x feature, fixed latency) between NUM_REQ convolution-lane requesters. Round-robin arbitration; at most one operand pair issued per cycle. Each requester ID is carried alongside the multiplier pipeline so every product returns to the lane that issued it. Sits between the lane controllers and the multiplier instance in the conv engine.

Parameters:
BIT_WIDTH, 8, operand width; product width is 2*BIT_WIDTH
NUM_REQ, 4, number of requesters (2..16)
MUL_LATENCY, 1, cycles from o_mul_en to valid i_mul_p (1..4)
ID_W, $clog2(NUM_REQ), requester-ID width (localparam)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_req_valid  in  NUM_REQ  per-lane request
i_req_weight  in  NUM_REQ*BIT_WIDTH  packed weights; lane k at [k*BIT_WIDTH +: BIT_WIDTH]
i_req_feature  in  NUM_REQ*BIT_WIDTH  packed features, same packing
i_hold  in  1  blocks new grants; in-flight work still drains
o_req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready
o_mul_a  out  BIT_WIDTH  registered weight to multiplier
o_mul_b  out  BIT_WIDTH  registered feature to multiplier
o_mul_en  out  1  one-cycle launch strobe, aligned with o_mul_a/b
i_mul_p  in  2*BIT_WIDTH  multiplier product
o_rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle
o_rsp_data  out  2*BIT_WIDTH  registered product
o_busy  out  1  high while any operation is in flight

Behaviour:
- Reset: o_mul_a/b=0, o_mul_en=0, o_rsp_valid=0, o_rsp_data=0, o_busy=0, tag pipe cleared, rr pointer=NUM_REQ-1 (lane 0 wins first). o_req_ready forced 0 while i_rst high.
- Arbitration (combinational): if !i_hold and any valid, grant the first valid lane searching upward from pointer+1, wrapping modulo NUM_REQ. o_req_ready has at most one bit set. Valid->ready path is combinational; requesters must not derive valid from ready.
- Pointer updates to the granted ID only on an accepted transfer. Unchanged under hold or when no request.
- Issue: transfer in cycle T -> at edge T+1, o_mul_a/b latch the granted lane's operands, o_mul_en=1, and tag {1,ID} enters the tag shift register. With no transfer, o_mul_en=0 and o_mul_a/b hold their values.
- Tag pipe: MUL_LATENCY stages, advances every cycle, no stall. When the tail is valid, i_mul_p is registered into o_rsp_data and o_rsp_valid = one-hot(ID) on the next edge.
- Latency: handshake T -> o_rsp_valid at T+2+MUL_LATENCY (3 cycles at default). Throughput is 1 result per cycle. Results return in issue order.
- No response backpressure: a lane must accept o_rsp_valid when it is asserted.
- o_rsp_data holds its last value when o_rsp_valid=0.
- o_busy = o_mul_en | any tag-pipe valid | any o_rsp_valid bit.
- A lane may be re-granted in the cycle after its previous grant when it is the only requester.
- Reset mid-operation: all in-flight tags are dropped and no response is emitted for them.
- i_hold asserted in the same cycle as a valid request: no grant. Deasserting i_hold resumes arbitration from the held pointer.
- Product width is 2*BIT_WIDTH, unsigned; no truncation.

Decomposition:
- Shared package/header: BIT_WIDTH default, MUL_LATENCY of the multiplier IP, NUM_REQ of the conv engine, tag-entry layout {valid, id}.
- One sub-module: rr_arbiter (NUM_REQ valid bits, pointer, i_hold -> one-hot grant + granted ID; pointer register inside, updated on accept).
- Tag pipe and operand registers stay in the top module.

Test Plan:
1. Lane 1 only, w=3, f=5, one cycle -> o_req_ready=4'b0010 same cycle; o_mul_en, a=3, b=5 next cycle; o_rsp_valid=4'b0010, o_rsp_data=15 at T+3; o_busy low at T+4.
2. All four lanes valid continuously (lane k: w=k+1, f=10) -> grants 0,1,2,3,0,... one per cycle; responses back-to-back: 10, 20, 30, 40 to lanes 0..3 in order.
3. Last grant = lane 2, then lanes 2 and 3 both valid -> lane 3 granted first, lane 2 the next cycle.
4. w=255, f=255 -> o_rsp_data=65025; w=0, f=200 -> 0; both routed to the correct lane.
5. i_hold raised with 2 ops in flight and lane 0 valid -> no ready; both in-flight responses still arrive; o_busy drops after drain; on hold release lane 0 granted next cycle.
6. Assert i_rst one cycle after a grant -> no o_rsp_valid ever appears for that op; after release, with lanes 0 and 3 valid, lane 0 is granted.
